// File: rtl/seg7_capture.sv
// seg7_capture: samples a time-multiplexed, active-low seven-segment display
// bus and recovers the hex value shown on each digit. A complete set of
// digits is presented on frame with a one-cycle frame_valid strobe.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an,
  input  logic              clr_err,
  output logic [4*NDIG-1:0] frame,
  output logic              frame_valid,
  output logic              err_pulse,
  output logic              err_sticky
);

  localparam int W = NDIG + 7;
  localparam logic [3:0] STABLE_C = 4'(STABLE);

  typedef enum logic [1:0] {
    WAIT,
    ARMED,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;
  logic [W-1:0]        sync1;
  logic [W-1:0]        s;
  logic [W-1:0]        p;
  logic [NDIG-1:0]     an_low;
  logic                an_ok;
  logic                same;
  logic                capture;
  logic [4:0]          dec;
  logic                cap_ok;
  logic                cap_err;
  logic [NDIG-1:0]     seen;
  logic [4*NDIG-1:0]   work;

  // Maps an active-low abcdefg pattern to {recognized, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0001100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign an_low  = ~s[W-1:7];
  assign an_ok   = ($countones(an_low) == 1);
  assign same    = (s == p);
  assign dec     = decode(s[6:0]);
  assign cap_ok  = capture & dec[4];
  assign cap_err = capture & ~dec[4];

  // Two-flop synchronizer on the pins plus a one-cycle history copy; resets to a blank display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      s     <= '1;
      p     <= '1;
    end else begin
      sync1 <= {an, seg};
      s     <= sync1;
      p     <= s;
    end
  end

  // Dwell-tracking state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a dwell must hold STABLE cycles, then is captured once.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      WAIT: begin
        if (same && an_ok) begin
          if (STABLE_C == 4'd1) begin
            capture    = 1'b1;
            state_next = DONE;
            cnt_next   = 4'd0;
          end else begin
            state_next = ARMED;
            cnt_next   = 4'd1;
          end
        end
      end
      ARMED: begin
        if (!same || !an_ok) begin
          state_next = WAIT;
          cnt_next   = 4'd0;
        end else if ((cnt + 4'd1) == STABLE_C) begin
          capture    = 1'b1;
          state_next = DONE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next   = cnt + 4'd1;
        end
      end
      DONE: begin
        if (!same || !an_ok) begin
          state_next = WAIT;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = WAIT;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Working slots take the latest recognized value for each digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (cap_ok && an_low[i]) begin
          work[4*i +: 4] <= dec[3:0];
        end
      end
    end
  end

  // Publish the frame the cycle after every digit has been seen, then start a new set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else if (&seen) begin
      frame       <= work;
      frame_valid <= 1'b1;
      seen        <= cap_ok ? an_low : '0;
    end else begin
      frame_valid <= 1'b0;
      if (cap_ok) begin
        seen <= seen | an_low;
      end
    end
  end

  // Error reporting; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse  <= cap_err;
      err_sticky <= cap_err | err_pulse | (err_sticky & ~clr_err);
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed bench for seg7_capture with NDIG=4, STABLE=3.
module tb_seg7_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clr_err;
  logic [15:0] frame;
  logic        frame_valid;
  logic        err_pulse;
  logic        err_sticky;

  int total;
  int bad;
  int fv_count;
  int err_count;

  seg7_capture #(.NDIG(4), .STABLE(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .clr_err     (clr_err),
    .frame       (frame),
    .frame_valid (frame_valid),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes seen while out of reset, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) fv_count++;
      if (err_pulse)   err_count++;
    end
  end

  // Drive the pins for a number of cycles; called at a falling edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] sg, input int cycles);
    an  = a;
    seg = sg;
    repeat (cycles) @(negedge clk);
  endtask

  // Show one pattern on digit idx.
  task automatic showDigit(input int idx, input logic [6:0] sg, input int cycles);
    logic [3:0] a;
    a = 4'hF;
    a[idx] = 1'b0;
    applyStimulus(a, sg, cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s wrong", tag);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    fv_count  = 0;
    err_count = 0;
    rst_n     = 1'b0;
    clr_err   = 1'b0;
    an        = 4'hF;
    seg       = 7'h7F;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_frame", 32'(frame), 32'h0);
    checkOutput("rst_fv", 32'(frame_valid), 32'h0);
    checkOutput("rst_errp", 32'(err_pulse), 32'h0);
    checkOutput("rst_errs", 32'(err_sticky), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 7'h7F, 2);

    // Clean scan 3,4,A,F with exact strobe latency on the last digit
    showDigit(0, 7'h06, 8);
    showDigit(1, 7'h4C, 8);
    showDigit(2, 7'h08, 8);
    showDigit(3, 7'h38, 6);
    checkOutput("scan_fv_early", 32'(frame_valid), 32'h0);
    checkOutput("scan_frame_early", 32'(frame), 32'h0);
    @(negedge clk);
    checkOutput("scan_fv", 32'(frame_valid), 32'h1);
    checkOutput("scan_frame", 32'(frame), 32'hFA43);
    @(negedge clk);
    checkOutput("scan_fv_low", 32'(frame_valid), 32'h0);
    applyStimulus(4'hF, 7'h7F, 2);
    checkOutput("scan_fv_count", 32'(fv_count), 32'd1);

    // Glitch rejection: 2 shown too briefly, 5 is captured
    showDigit(1, 7'h12, 2);
    showDigit(1, 7'h24, 8);
    showDigit(0, 7'h01, 8);
    showDigit(2, 7'h20, 8);
    showDigit(3, 7'h0F, 8);
    checkOutput("glitch_frame", 32'(frame), 32'h7650);
    checkOutput("glitch_fv_count", 32'(fv_count), 32'd2);

    // Blanking and multi-select never capture
    applyStimulus(4'hF, 7'h7F, 5);
    applyStimulus(4'hC, 7'h00, 10);
    applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("multi_err_count", 32'(err_count), 32'd0);
    checkOutput("multi_fv_count", 32'(fv_count), 32'd2);
    checkOutput("multi_errs", 32'(err_sticky), 32'h0);

    // Unrecognized pattern on digit 2
    showDigit(2, 7'h7E, 8);
    checkOutput("bad_err_count", 32'(err_count), 32'd1);
    checkOutput("bad_errs", 32'(err_sticky), 32'h1);
    showDigit(0, 7'h01, 8);
    showDigit(1, 7'h4F, 8);
    showDigit(3, 7'h0C, 8);
    checkOutput("bad_no_frame", 32'(fv_count), 32'd2);
    showDigit(2, 7'h00, 8);
    checkOutput("bad_fv_count", 32'(fv_count), 32'd3);
    checkOutput("bad_frame", 32'(frame), 32'h9810);
    checkOutput("bad_errs_held", 32'(err_sticky), 32'h1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    checkOutput("clr_errs", 32'(err_sticky), 32'h0);

    // Long dwell captures once; rescan overwrites a slot
    showDigit(1, 7'h60, 8);
    showDigit(2, 7'h31, 8);
    showDigit(3, 7'h42, 8);
    showDigit(0, 7'h30, 50);
    checkOutput("dwell_fv_count", 32'(fv_count), 32'd4);
    checkOutput("dwell_frame", 32'(frame), 32'hDCBE);
    showDigit(1, 7'h38, 8);
    showDigit(2, 7'h38, 8);
    showDigit(3, 7'h38, 8);
    checkOutput("dwell_single", 32'(fv_count), 32'd4);
    showDigit(1, 7'h0F, 8);
    showDigit(0, 7'h01, 8);
    checkOutput("rescan_fv_count", 32'(fv_count), 32'd5);
    checkOutput("rescan_frame", 32'(frame), 32'hFF70);

    // Reset mid-frame discards partial work
    showDigit(3, 7'h7E, 8);
    checkOutput("pre_rst_errs", 32'(err_sticky), 32'h1);
    showDigit(0, 7'h06, 8);
    showDigit(1, 7'h4C, 8);
    showDigit(2, 7'h08, 4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_frame", 32'(frame), 32'h0);
    checkOutput("midrst_fv", 32'(frame_valid), 32'h0);
    checkOutput("midrst_errs", 32'(err_sticky), 32'h0);
    checkOutput("midrst_errp", 32'(err_pulse), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    showDigit(2, 7'h08, 8);
    showDigit(3, 7'h38, 8);
    checkOutput("post_rst_partial", 32'(fv_count), 32'd5);
    showDigit(0, 7'h06, 8);
    showDigit(1, 7'h4C, 8);
    checkOutput("post_rst_fv_count", 32'(fv_count), 32'd6);
    checkOutput("post_rst_frame", 32'(frame), 32'hFA43);
    checkOutput("final_err_count", 32'(err_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
